stepper_seq_gen: RTL and testbench

Parametrised stepper-motor phase sequencer. Generates 4-coil drive patterns in wave-drive, two-phase full-step or half-step mode. Steps are paced by an internal programmable rate divider rather than by an external step clock. It executes commanded moves of N steps with start/stop/busy/done handshaking and keeps a signed position count. It sits between the control/register logic and the coil driver outputs.

---
 rtl/stepper_seq_gen.sv | 177 +++++++++++++++++
 tb/tb_stepper_seq_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : stepper_seq_gen
//  Brief    : 4-coil stepper phase sequencer (wave / two-phase / half-step)
//             with internal rate divider, N-step moves and position count.
//  Revision : 1.0  initial release
// ============================================================================
module stepper_seq_gen #(
    parameter int CNT_W  = 16,
    parameter int STEP_W = 16,
    parameter int POS_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              dir,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  period,
    input  logic [STEP_W-1:0] nsteps,
    input  logic              hold_en,
    output logic [3:0]        coils,
    output logic              busy,
    output logic              done,
    output logic              step_pulse,
    output logic [POS_W-1:0]  position
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]        r_state,     w_state_nxt;
    logic [2:0]        r_index,     w_index_nxt;
    logic [POS_W-1:0]  r_position,  w_position_nxt;
    logic [CNT_W-1:0]  r_div,       w_div_nxt;
    logic [STEP_W-1:0] r_remaining, w_remaining_nxt;
    logic [CNT_W-1:0]  r_period,    w_period_nxt;
    logic              r_dir,       w_dir_nxt;
    logic              r_half,      w_half_nxt;
    logic              r_two,       w_two_nxt;
    logic              r_first,     w_first_nxt;
    logic [3:0]        r_coils,     w_coils_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_step,      w_step_nxt;

    logic [CNT_W-1:0]  w_period_in;
    logic              w_snap;
    logic [2:0]        w_mag;
    logic [2:0]        w_index_step;
    logic [POS_W-1:0]  w_position_step;

    function automatic logic [3:0] phase_of(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1010;
            3'd2:    pat = 4'b0010;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0100;
            3'd5:    pat = 4'b0101;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    assign w_period_in = (period == '0) ? CNT_W'(1) : period;

    // Full-step modes may start on an index of the wrong parity; the first
    // step of the move then takes a single half-step to land on a valid one.
    assign w_snap = ~r_half & r_first & (r_two ? ~r_index[0] : r_index[0]);
    assign w_mag  = (r_half | w_snap) ? 3'd1 : 3'd2;

    assign w_index_step    = r_dir ? (r_index + w_mag) : (r_index - w_mag);
    assign w_position_step = r_dir ? (r_position + POS_W'(w_mag))
                                   : (r_position - POS_W'(w_mag));

    always_comb begin
        w_state_nxt     = r_state;
        w_index_nxt     = r_index;
        w_position_nxt  = r_position;
        w_div_nxt       = r_div;
        w_remaining_nxt = r_remaining;
        w_period_nxt    = r_period;
        w_dir_nxt       = r_dir;
        w_half_nxt      = r_half;
        w_two_nxt       = r_two;
        w_first_nxt     = r_first;
        w_done_nxt      = 1'b0;
        w_step_nxt      = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (start && !stop) begin
                    if (nsteps != '0) begin
                        w_state_nxt     = c_ST_RUN;
                        w_dir_nxt       = dir;
                        w_half_nxt      = mode[1];
                        w_two_nxt       = (mode == 2'b01);
                        w_period_nxt    = w_period_in;
                        w_remaining_nxt = nsteps;
                        w_div_nxt       = w_period_in - CNT_W'(1);
                        w_first_nxt     = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                // Abort has priority over a step event in the same cycle.
                if (stop) begin
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_div == '0) begin
                    w_index_nxt     = w_index_step;
                    w_position_nxt  = w_position_step;
                    w_remaining_nxt = r_remaining - STEP_W'(1);
                    w_div_nxt       = r_period - CNT_W'(1);
                    w_first_nxt     = 1'b0;
                    w_step_nxt      = 1'b1;
                    if (r_remaining == STEP_W'(1)) begin
                        w_state_nxt = c_ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div - CNT_W'(1);
                end
            end
        endcase

        w_busy_nxt  = (w_state_nxt == c_ST_RUN);
        w_coils_nxt = (w_busy_nxt || hold_en) ? phase_of(w_index_nxt) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_index     <= '0;
            r_position  <= '0;
            r_div       <= '0;
            r_remaining <= '0;
            r_period    <= '0;
            r_dir       <= 1'b0;
            r_half      <= 1'b0;
            r_two       <= 1'b0;
            r_first     <= 1'b0;
            r_coils     <= 4'b0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_step      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_position  <= w_position_nxt;
            r_div       <= w_div_nxt;
            r_remaining <= w_remaining_nxt;
            r_period    <= w_period_nxt;
            r_dir       <= w_dir_nxt;
            r_half      <= w_half_nxt;
            r_two       <= w_two_nxt;
            r_first     <= w_first_nxt;
            r_coils     <= w_coils_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_step      <= w_step_nxt;
        end
    end

    assign coils      = r_coils;
    assign busy       = r_busy;
    assign done       = r_done;
    assign step_pulse = r_step;
    assign position   = r_position;

endmodule
`default_nettype wire

// File: tb/tb_stepper_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stepper_seq_gen
//  Brief    : Directed self-checking bench for stepper_seq_gen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stepper_seq_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, stop, dir, hold_en;
    logic [1:0]  mode;
    logic [15:0] period, nsteps;
    logic [3:0]  coils, coils4;
    logic        busy, done, step_pulse, busy4, done4, step4;
    logic [15:0] position;
    logic [3:0]  pos4;

    int checks   = 0;
    int failures = 0;

    stepper_seq_gen #(.CNT_W(16), .STEP_W(16), .POS_W(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
        .mode(mode), .period(period), .nsteps(nsteps), .hold_en(hold_en),
        .coils(coils), .busy(busy), .done(done), .step_pulse(step_pulse),
        .position(position)
    );

    stepper_seq_gen #(.CNT_W(16), .STEP_W(16), .POS_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
        .mode(mode), .period(period), .nsteps(nsteps), .hold_en(hold_en),
        .coils(coils4), .busy(busy4), .done(done4), .step_pulse(step4),
        .position(pos4)
    );

    typedef struct packed {
        logic [1:0]  mode;
        logic        dir;
        logic [15:0] period;
        logic [15:0] nsteps;
        int          exp_cyc;
        logic [3:0]  exp_coils;
        int          exp_pos;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic launch(input logic [1:0] m, input logic d,
                          input logic [15:0] p, input logic [15:0] n);
        mode = m; dir = d; period = p; nsteps = n; start = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_b [4];
        int got, steps;

        vecs[0] = '{2'b10, 1'b1, 16'd3, 16'd4, 13, 4'b0100,  4};
        vecs[1] = '{2'b01, 1'b0, 16'd1, 16'd3,  4, 4'b0110, -5};
        vecs[2] = '{2'b00, 1'b1, 16'd2, 16'd3,  7, 4'b0001,  6};
        vecs[3] = '{2'b11, 1'b0, 16'd0, 16'd5,  6, 4'b0110, -5};
        vecs[4] = '{2'b01, 1'b1, 16'd4, 16'd2,  9, 4'b0110,  3};
        vecs[5] = '{2'b00, 1'b0, 16'd1, 16'd4,  5, 4'b1000, -8};

        exp_b[0] = 4'b1010; exp_b[1] = 4'b0010;
        exp_b[2] = 4'b0110; exp_b[3] = 4'b0100;

        reset = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b1; hold_en = 1'b1;
        mode = 2'b10; period = 16'd1; nsteps = 16'd0;

        // Reset state and idle hold behaviour
        tick(); tick();
        chk("rst_coils", int'(coils), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_pos",   int'($signed(position)), 0);
        reset = 1'b0;
        tick();
        chk("hold_coils", int'(coils), 8);
        hold_en = 1'b0;
        tick();
        chk("nohold_coils", int'(coils), 0);
        hold_en = 1'b1;
        tick();
        chk("rehold_coils", int'(coils), 8);

        // Half-step move, cycle-exact step timing
        do_reset();
        launch(2'b10, 1'b1, 16'd3, 16'd4);
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) begin
                start = 1'b0;
                chk("b_busy1", int'(busy), 1);
            end
            chk("b_step", int'(step_pulse), (c == 4 || c == 7 || c == 10 || c == 13) ? 1 : 0);
            chk("b_done", int'(done), (c == 13) ? 1 : 0);
            if (c % 3 == 1 && c > 1)
                chk("b_coils", int'(coils), int'(exp_b[(c - 4) / 3]));
        end
        chk("b_pos",  int'($signed(position)), 4);
        chk("b_busy", int'(busy), 0);

        // Stop mid-move
        do_reset();
        launch(2'b00, 1'b1, 16'd5, 16'd100);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) start = 1'b0;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_done",  int'(done), 1);
        chk("stop_busy",  int'(busy), 0);
        chk("stop_pos",   int'($signed(position)), 4);
        chk("stop_coils", int'(coils), 4);
        steps = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (step_pulse) steps++;
        end
        chk("stop_nomore", steps, 0);
        chk("stop_pos2",   int'($signed(position)), 4);

        // Stop coinciding with a step event
        do_reset();
        launch(2'b10, 1'b1, 16'd2, 16'd10);
        tick();
        start = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stopev_step",  int'(step_pulse), 0);
        chk("stopev_done",  int'(done), 1);
        chk("stopev_pos",   int'($signed(position)), 0);
        chk("stopev_coils", int'(coils), 8);

        // Zero-step start
        do_reset();
        launch(2'b10, 1'b1, 16'd1, 16'd0);
        tick();
        start = 1'b0;
        chk("zero_done", int'(done), 1);
        chk("zero_busy", int'(busy), 0);
        tick();
        chk("zero_done2", int'(done), 0);
        chk("zero_busy2", int'(busy), 0);

        // Start together with stop
        launch(2'b10, 1'b1, 16'd1, 16'd5);
        stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_done", int'(done), 0);
        chk("ss_busy", int'(busy), 0);
        tick();
        chk("ss_busy2", int'(busy), 0);

        // Start and input changes during RUN are ignored; restart on done
        do_reset();
        launch(2'b10, 1'b1, 16'd1, 16'd3);
        tick();
        chk("run_busy", int'(busy), 1);
        nsteps = 16'd10; dir = 1'b0; mode = 2'b00;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("run_done",  int'(done), 1);
        chk("run_pos",   int'($signed(position)), 3);
        chk("run_coils", int'(coils), 6);
        chk("run_busyE", int'(busy), 0);
        launch(2'b10, 1'b1, 16'd1, 16'd1);
        tick();
        start = 1'b0;
        chk("re_busy", int'(busy), 1);
        tick();
        chk("re_done", int'(done), 1);
        chk("re_step", int'(step_pulse), 1);
        chk("re_pos",  int'($signed(position)), 4);

        // Position wrap on the 4-bit instance
        do_reset();
        launch(2'b10, 1'b1, 16'd1, 16'd10);
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 8) chk("wrap_p7",  int'($signed(pos4)), 7);
            if (c == 9) chk("wrap_m8",  int'($signed(pos4)), -8);
        end
        chk("wrap_end",  int'($signed(pos4)), -6);
        chk("wrap_done", int'(done4), 1);
        chk("wrap_pos16", int'($signed(position)), 10);

        // Reset during a move
        do_reset();
        launch(2'b10, 1'b1, 16'd1, 16'd100);
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        chk("mr_coils", int'(coils), 0);
        chk("mr_busy",  int'(busy), 0);
        chk("mr_pos",   int'($signed(position)), 0);
        chk("mr_step",  int'(step_pulse), 0);
        chk("mr_done",  int'(done), 0);
        reset = 1'b0;
        got = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done || busy) got++;
        end
        chk("mr_quiet", got, 0);

        // Table of complete moves from reset
        for (int i = 0; i < 6; i++) begin
            do_reset();
            launch(vecs[i].mode, vecs[i].dir, vecs[i].period, vecs[i].nsteps);
            got = -1;
            steps = 0;
            for (int c = 1; c <= 400; c++) begin
                tick();
                if (c == 1) start = 1'b0;
                if (step_pulse) steps++;
                if (done) begin
                    got = c;
                    break;
                end
            end
            chk($sformatf("v%0d_cyc", i),   got, vecs[i].exp_cyc);
            chk($sformatf("v%0d_steps", i), steps, int'(vecs[i].nsteps));
            chk($sformatf("v%0d_coils", i), int'(coils), int'(vecs[i].exp_coils));
            chk($sformatf("v%0d_pos", i),   int'($signed(position)), vecs[i].exp_pos);
            chk($sformatf("v%0d_busy", i),  int'(busy), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
